xheep_fpga_rst_seq: RTL

FPGA-top reset and boot sequencer feeding `x_heep_system` (`rst_ni`, `boot_select_i`, `execute_from_flash_i`) and capturing its exit status. It sits directly upstream of the system instance in the Xilinx wrapper.
- Merges the board reset with an optional PS-GPIO soft-reset request.
- Guarantees a minimum reset pulse and freezes the boot straps while the system runs.
- Latches `exit_valid`/`exit_value` as sticky status readable by the PS and LEDs.

---
 rtl/xheep_fpga_pkg.sv | 13 +
 rtl/sync.sv | 23 ++
 rtl/xheep_fpga_sync_filter.sv | 53 +++++
 rtl/xheep_fpga_rst_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/xheep_fpga_pkg.sv
// Shared types and widths for the FPGA reset/boot sequencer.
package xheep_fpga_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    EXITED
  } rst_seq_state_e;

  localparam int unsigned EXIT_VALUE_W   = 32;
  localparam int unsigned SOFT_RST_CNT_W = 8;

endpackage

// File: rtl/sync.sv
// Plain 2-flop synchronizer cell with a configurable reset value.
module sync #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_gen,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      q_o    <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/xheep_fpga_sync_filter.sv
// Synchronizes an active-low request and accepts it only after FILTER_CYCLES stable-low cycles.
module xheep_fpga_sync_filter #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_VALUE   = 1'b1
) (
  input  logic clk_gen,
  input  logic rst_n,
  input  logic async_ni,
  output logic req_no
);

  localparam logic [7:0] LastCnt = 8'(FILTER_CYCLES - 1);

  logic       sync_n;
  logic [7:0] low_cnt_q, low_cnt_d;
  logic       req_n_q, req_n_d;

  sync #(
    .RESET_VALUE(RESET_VALUE)
  ) u_sync (
    .clk_gen(clk_gen),
    .rst_n  (rst_n),
    .d_i    (async_ni),
    .q_o    (sync_n)
  );

  // low_cnt_q holds the number of consecutive low samples already seen.
  always_comb begin
    low_cnt_d = low_cnt_q;
    req_n_d   = req_n_q;
    if (sync_n) begin
      low_cnt_d = '0;
      req_n_d   = 1'b1;
    end else if (low_cnt_q == LastCnt) begin
      req_n_d = 1'b0;
    end else begin
      low_cnt_d = low_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_q <= '0;
      req_n_q   <= 1'b1;
    end else begin
      low_cnt_q <= low_cnt_d;
      req_n_q   <= req_n_d;
    end
  end

  assign req_no = req_n_q;

endmodule

// File: rtl/xheep_fpga_rst_seq.sv
// Reset/boot sequencer in front of x_heep_system: minimum reset pulse, frozen straps, exit status.
// Define XHEEP_PS_CTRL_EN to take the soft reset and straps from the PS instead of board pins.
module xheep_fpga_rst_seq
  import xheep_fpga_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 1024,
  parameter int unsigned FILTER_CYCLES   = 4
) (
  input  logic                      clk_gen,
  input  logic                      rst_n,
  input  logic                      ps_rst_ni,
  input  logic                      ps_boot_select_i,
  input  logic                      ps_exec_flash_i,
  input  logic                      board_boot_select_i,
  input  logic                      board_exec_flash_i,
  input  logic                      exit_valid_i,
  input  logic [EXIT_VALUE_W-1:0]   exit_value_i,
  output logic                      sys_rst_no,
  output logic                      boot_select_o,
  output logic                      execute_from_flash_o,
  output logic                      status_valid_o,
  output logic [EXIT_VALUE_W-1:0]   status_value_o,
  output logic [SOFT_RST_CNT_W-1:0] soft_rst_count_o
);

  localparam logic [15:0] HoldLast = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [SOFT_RST_CNT_W-1:0] SoftCntOne = 1;

  logic boot_sync, exec_sync, req_n;

`ifdef XHEEP_PS_CTRL_EN
  sync #(
    .RESET_VALUE(1'b0)
  ) u_boot_sync (
    .clk_gen(clk_gen),
    .rst_n  (rst_n),
    .d_i    (ps_boot_select_i),
    .q_o    (boot_sync)
  );

  sync #(
    .RESET_VALUE(1'b0)
  ) u_exec_sync (
    .clk_gen(clk_gen),
    .rst_n  (rst_n),
    .d_i    (ps_exec_flash_i),
    .q_o    (exec_sync)
  );

  xheep_fpga_sync_filter #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .RESET_VALUE  (1'b1)
  ) u_ps_rst_filter (
    .clk_gen (clk_gen),
    .rst_n   (rst_n),
    .async_ni(ps_rst_ni),
    .req_no  (req_n)
  );

  logic unused_board;
  assign unused_board = ^{board_boot_select_i, board_exec_flash_i};
`else
  sync #(
    .RESET_VALUE(1'b0)
  ) u_boot_sync (
    .clk_gen(clk_gen),
    .rst_n  (rst_n),
    .d_i    (board_boot_select_i),
    .q_o    (boot_sync)
  );

  sync #(
    .RESET_VALUE(1'b0)
  ) u_exec_sync (
    .clk_gen(clk_gen),
    .rst_n  (rst_n),
    .d_i    (board_exec_flash_i),
    .q_o    (exec_sync)
  );

  assign req_n = 1'b1;

  logic unused_ps;
  assign unused_ps = ^{ps_rst_ni, ps_boot_select_i, ps_exec_flash_i, 8'(FILTER_CYCLES)};
`endif

  rst_seq_state_e            state_q, state_d;
  logic [15:0]               hold_cnt_q, hold_cnt_d;
  logic                      sys_rst_n_q, sys_rst_n_d;
  logic                      boot_q, boot_d, exec_q, exec_d;
  logic                      status_valid_q, status_valid_d;
  logic [EXIT_VALUE_W-1:0]   status_value_q, status_value_d;
  logic [SOFT_RST_CNT_W-1:0] soft_cnt_q, soft_cnt_d;
  logic                      enter_hold;

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    boot_d         = boot_q;
    exec_d         = exec_q;
    status_valid_d = status_valid_q;
    status_value_d = status_value_q;
    soft_cnt_d     = soft_cnt_q;
    enter_hold     = 1'b0;

    unique case (state_q)
      HOLD: begin
        if (!req_n) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = RUN;
          hold_cnt_d = '0;
          boot_d     = boot_sync;
          exec_d     = exec_sync;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      // A reset request outranks a simultaneous exit.
      RUN: begin
        if (!req_n) begin
          enter_hold = 1'b1;
        end else if (exit_valid_i) begin
          state_d        = EXITED;
          status_valid_d = 1'b1;
          status_value_d = exit_value_i;
        end
      end
      EXITED: begin
        if (!req_n) enter_hold = 1'b1;
      end
      default: state_d = HOLD;
    endcase

    if (enter_hold) begin
      state_d        = HOLD;
      hold_cnt_d     = '0;
      status_valid_d = 1'b0;
      status_value_d = '0;
      if (soft_cnt_q != '1) soft_cnt_d = soft_cnt_q + SoftCntOne;
    end

    sys_rst_n_d = (state_d != HOLD);
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HOLD;
      hold_cnt_q     <= '0;
      sys_rst_n_q    <= 1'b0;
      boot_q         <= 1'b0;
      exec_q         <= 1'b0;
      status_valid_q <= 1'b0;
      status_value_q <= '0;
      soft_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      sys_rst_n_q    <= sys_rst_n_d;
      boot_q         <= boot_d;
      exec_q         <= exec_d;
      status_valid_q <= status_valid_d;
      status_value_q <= status_value_d;
      soft_cnt_q     <= soft_cnt_d;
    end
  end

  assign sys_rst_no           = sys_rst_n_q;
  assign boot_select_o        = boot_q;
  assign execute_from_flash_o = exec_q;
  assign status_valid_o       = status_valid_q;
  assign status_value_o       = status_value_q;
  assign soft_rst_count_o     = soft_cnt_q;

endmodule
